alu_sequencer: RTL and testbench

- Single-cycle-issue controller for the cpu6502 ALU datapath. It accepts an operation request (4-bit op, two operands, carry-in) and drives the ALU operand buses and control strobes for one execute cycle.
- It captures the ALU hold-register result and the carry/overflow signals, then updates the N/Z/C/V flags and pulses done.
- It sits between the instruction decoder (or a test harness) and the ALU instance.

---
 rtl/alu_seq_pkg.sv | 50 +++++
 rtl/alu_seq_decode.sv | 78 +++++++
 rtl/alu_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: op codes, FSM encoding,
// ALU control word layout and per-op update masks.
package alu_seq_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADC = 4'd0;
    localparam op_t OP_SBC = 4'd1;
    localparam op_t OP_AND = 4'd2;
    localparam op_t OP_ORA = 4'd3;
    localparam op_t OP_EOR = 4'd4;
    localparam op_t OP_ASL = 4'd5;
    localparam op_t OP_ROL = 4'd6;
    localparam op_t OP_LSR = 4'd7;
    localparam op_t OP_ROR = 4'd8;
    localparam op_t OP_INC = 4'd9;
    localparam op_t OP_DEC = 4'd10;
    localparam op_t OP_CMP = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Which architectural state an op writes; N/Z are written by every legal op.
    typedef logic [2:0] upd_t;
    localparam upd_t UPD_C   = 3'b001;
    localparam upd_t UPD_V   = 3'b010;
    localparam upd_t UPD_RES = 3'b100;

    // ALU input enables and function selects, one bit per strobe.
    typedef struct packed {
        logic sb_add;
        logic db_add;
        logic db_n_add;
        logic add_0;
        logic addc_1;
        logic sums;
        logic ands;
        logic eors;
        logic ors;
        logic srs;
    } ctrl_t;

    function automatic logic op_is_legal(input op_t op);
        return (op <= OP_CMP);
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Op decode: turns the latched op and carry into the ALU control word,
// the B-bus source select and the result/flag update mask.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  op_t   i_op,
    input  logic  i_carry,
    output ctrl_t o_ctrl,
    output logic  o_db_sel_a,
    output upd_t  o_upd
);

    // Control word lookup; unknown ops leave everything deasserted.
    always_comb begin
        o_ctrl     = '0;
        o_db_sel_a = 1'b0;
        o_upd      = '0;
        case (i_op)
            OP_ADC: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.db_add = 1'b1; o_ctrl.sums = 1'b1;
                o_ctrl.addc_1 = i_carry;
                o_upd = UPD_C | UPD_V | UPD_RES;
            end
            OP_SBC: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.db_n_add = 1'b1; o_ctrl.sums = 1'b1;
                o_ctrl.addc_1 = i_carry;
                o_upd = UPD_C | UPD_V | UPD_RES;
            end
            OP_CMP: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.db_n_add = 1'b1; o_ctrl.sums = 1'b1;
                o_ctrl.addc_1 = 1'b1;
                o_upd = UPD_C;
            end
            OP_AND: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.db_add = 1'b1; o_ctrl.ands = 1'b1;
                o_upd = UPD_RES;
            end
            OP_ORA: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.db_add = 1'b1; o_ctrl.ors = 1'b1;
                o_upd = UPD_RES;
            end
            OP_EOR: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.db_add = 1'b1; o_ctrl.eors = 1'b1;
                o_upd = UPD_RES;
            end
            OP_ASL, OP_ROL: begin
                // Shift left is A + A, so A is routed onto the B bus as well.
                o_db_sel_a = 1'b1;
                o_ctrl.sb_add = 1'b1; o_ctrl.db_add = 1'b1; o_ctrl.sums = 1'b1;
                o_ctrl.addc_1 = (i_op == OP_ROL) ? i_carry : 1'b0;
                o_upd = UPD_C | UPD_RES;
            end
            OP_LSR, OP_ROR: begin
                o_ctrl.sb_add = 1'b1; o_ctrl.srs = 1'b1;
                o_ctrl.addc_1 = (i_op == OP_ROR) ? i_carry : 1'b0;
                o_upd = UPD_C | UPD_RES;
            end
            OP_INC: begin
                // 0 + A + 1 with A presented on the B side.
                o_db_sel_a = 1'b1;
                o_ctrl.add_0 = 1'b1; o_ctrl.db_add = 1'b1; o_ctrl.sums = 1'b1;
                o_ctrl.addc_1 = 1'b1;
                o_upd = UPD_RES;
            end
            OP_DEC: begin
                // B side left undriven floats to 0xFF inside the ALU: A + 0xFF.
                o_ctrl.sb_add = 1'b1; o_ctrl.sums = 1'b1;
                o_upd = UPD_RES;
            end
            default: begin
                o_ctrl     = '0;
                o_db_sel_a = 1'b0;
                o_upd      = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Single-issue sequencer driving the 6502 ALU datapath for one execute cycle.
//
// state  | meaning
// IDLE   | waiting for i_start; ALU controls and buses held at 0
// EXEC   | controls/buses driven from latched request; ALU latches mid-cycle
// DONE   | result captured; o_done pulses in the following cycle
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int DATA_W = 8
)(
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic [OP_W-1:0]   i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_carry,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_illegal,
    output logic [DATA_W-1:0] o_result,
    output logic              o_n,
    output logic              o_z,
    output logic              o_c,
    output logic              o_v,
    output logic [DATA_W-1:0] o_sb,
    output logic [DATA_W-1:0] o_db,
    output logic              o_sb_add,
    output logic              o_db_add,
    output logic              o_db_n_add,
    output logic              o_0_add,
    output logic              o_1_addc,
    output logic              o_sums,
    output logic              o_ands,
    output logic              o_eors,
    output logic              o_ors,
    output logic              o_srs,
    input  logic [DATA_W-1:0] i_add,
    input  logic              i_acr,
    input  logic              i_avr
);

    state_t            r_state;
    state_t            w_state_nxt;
    op_t               r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_carry;
    logic [DATA_W-1:0] r_result;
    logic              r_n, r_z, r_c, r_v;
    logic              r_done;
    logic              r_illegal;

    ctrl_t             w_ctrl;
    ctrl_t             w_ctrl_out;
    logic              w_db_sel_a;
    upd_t              w_upd;
    logic [DATA_W-1:0] w_sb;
    logic [DATA_W-1:0] w_db;

    alu_seq_decode u_decode (
        .i_op       (r_op),
        .i_carry    (r_carry),
        .o_ctrl     (w_ctrl),
        .o_db_sel_a (w_db_sel_a),
        .o_upd      (w_upd)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state logic; illegal ops skip the execute cycle entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = op_is_legal(op_t'(i_op)) ? S_EXEC : S_DONE;
            S_EXEC:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ALU drive: only the execute cycle presents the request to the ALU.
    always_comb begin
        w_ctrl_out = '0;
        w_sb       = '0;
        w_db       = '0;
        if (r_state == S_EXEC) begin
            w_ctrl_out = w_ctrl;
            w_sb       = r_a;
            w_db       = w_db_sel_a ? r_a : r_b;
        end
    end

    // Request capture, accepted only while idle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
        end else if (r_state == S_IDLE && i_start) begin
            r_op    <= op_t'(i_op);
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_carry;
        end
    end

    // Result and flag update at the closing edge of the execute cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_result <= '0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_n <= i_add[DATA_W-1];
            r_z <= (i_add == '0);
            if (|(w_upd & UPD_RES)) r_result <= i_add;
            if (|(w_upd & UPD_C))   r_c      <= i_acr;
            if (|(w_upd & UPD_V))   r_v      <= i_avr;
        end
    end

    // Completion pulse, registered out of DONE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_done    <= (r_state == S_DONE);
            r_illegal <= (r_state == S_DONE) && !op_is_legal(r_op);
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = r_done;
    assign o_illegal  = r_illegal;
    assign o_result   = r_result;
    assign o_n        = r_n;
    assign o_z        = r_z;
    assign o_c        = r_c;
    assign o_v        = r_v;
    assign o_sb       = w_sb;
    assign o_db       = w_db;
    assign o_sb_add   = w_ctrl_out.sb_add;
    assign o_db_add   = w_ctrl_out.db_add;
    assign o_db_n_add = w_ctrl_out.db_n_add;
    assign o_0_add    = w_ctrl_out.add_0;
    assign o_1_addc   = w_ctrl_out.addc_1;
    assign o_sums     = w_ctrl_out.sums;
    assign o_ands     = w_ctrl_out.ands;
    assign o_eors     = w_ctrl_out.eors;
    assign o_ors      = w_ctrl_out.ors;
    assign o_srs      = w_ctrl_out.srs;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a simple 6502-style ALU stands in for the datapath,
// directed vectors come from a table, random ops are checked against an
// instruction-level model of the 6502 arithmetic and flag rules.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       cin = 1'b0;

    logic       o_busy, o_done, o_illegal, o_n, o_z, o_c, o_v;
    logic [7:0] o_result, o_sb, o_db;
    logic       o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc;
    logic       o_sums, o_ands, o_eors, o_ors, o_srs;

    logic [7:0] alu_hold = 8'h00;
    logic [7:0] alu_res;
    logic       acr, avr;

    int total = 0;
    int bad   = 0;

    // Instruction-level model state.
    logic [7:0] m_res = 8'h00;
    logic       m_n = 1'b0, m_z = 1'b0, m_c = 1'b0, m_v = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op),
        .i_a(a), .i_b(b), .i_carry(cin),
        .o_busy(o_busy), .o_done(o_done), .o_illegal(o_illegal),
        .o_result(o_result), .o_n(o_n), .o_z(o_z), .o_c(o_c), .o_v(o_v),
        .o_sb(o_sb), .o_db(o_db),
        .o_sb_add(o_sb_add), .o_db_add(o_db_add), .o_db_n_add(o_db_n_add),
        .o_0_add(o_0_add), .o_1_addc(o_1_addc),
        .o_sums(o_sums), .o_ands(o_ands), .o_eors(o_eors), .o_ors(o_ors), .o_srs(o_srs),
        .i_add(alu_hold), .i_acr(acr), .i_avr(avr)
    );

    // Stand-in ALU: combinational carry/overflow, hold register on negedge.
    always_comb begin
        logic [7:0] ai, bi;
        logic [8:0] s;
        ai = o_sb_add ? o_sb : 8'h00;
        bi = o_db_add ? o_db : (o_db_n_add ? ~o_db : 8'hFF);
        s  = {1'b0, ai} + {1'b0, bi} + {8'h00, o_1_addc};
        alu_res = 8'h00;
        acr = 1'b0;
        avr = 1'b0;
        if (o_sums) begin
            alu_res = s[7:0];
            acr = s[8];
            avr = (ai[7] == bi[7]) && (s[7] != ai[7]);
        end else if (o_ands) alu_res = ai & bi;
        else if (o_ors)  alu_res = ai | bi;
        else if (o_eors) alu_res = ai ^ bi;
        else if (o_srs) begin
            alu_res = {o_1_addc, ai[7:1]};
            acr = ai[0];
        end
    end

    always @(negedge clk) alu_hold <= alu_res;

    function automatic logic [9:0] ctl_now();
        return {o_sb_add, o_db_add, o_db_n_add, o_0_add, o_1_addc,
                o_sums, o_ands, o_eors, o_ors, o_srs};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_nz(input int r);
        logic [7:0] r8;
        r8  = r[7:0];
        m_n = r8[7];
        m_z = (r8 == 8'h00);
    endtask

    // 6502 semantics in plain integer arithmetic.
    task automatic model_apply(input logic [3:0] op_i, input logic [7:0] a_i,
                               input logic [7:0] b_i, input logic c_i, output logic ill);
        int ua, ub, sa, sb, cc, r, sr;
        ua = int'(a_i);
        ub = int'(b_i);
        sa = int'($signed(a_i));
        sb = int'($signed(b_i));
        cc = c_i ? 1 : 0;
        ill = 1'b0;
        case (op_i)
            4'd0: begin
                r = ua + ub + cc; sr = sa + sb + cc;
                m_c = (r > 255); m_v = (sr < -128) || (sr > 127);
                m_res = r[7:0]; set_nz(r);
            end
            4'd1: begin
                r = ua - ub - (1 - cc); sr = sa - sb - (1 - cc);
                m_c = (r >= 0); m_v = (sr < -128) || (sr > 127);
                m_res = r[7:0]; set_nz(r);
            end
            4'd2: begin r = ua & ub; m_res = r[7:0]; set_nz(r); end
            4'd3: begin r = ua | ub; m_res = r[7:0]; set_nz(r); end
            4'd4: begin r = ua ^ ub; m_res = r[7:0]; set_nz(r); end
            4'd5: begin r = ua * 2;      m_c = a_i[7]; m_res = r[7:0]; set_nz(r); end
            4'd6: begin r = ua * 2 + cc; m_c = a_i[7]; m_res = r[7:0]; set_nz(r); end
            4'd7: begin r = ua / 2;            m_c = a_i[0]; m_res = r[7:0]; set_nz(r); end
            4'd8: begin r = ua / 2 + cc * 128; m_c = a_i[0]; m_res = r[7:0]; set_nz(r); end
            4'd9:  begin r = ua + 1; m_res = r[7:0]; set_nz(r); end
            4'd10: begin r = ua - 1; m_res = r[7:0]; set_nz(r); end
            4'd11: begin r = ua - ub; m_c = (r >= 0); set_nz(r); end
            default: ill = 1'b1;
        endcase
    endtask

    // Issue one request; report control word and busy seen in the first cycle
    // after acceptance, and how many edges later o_done appeared (0 = never).
    task automatic run_op(input logic [3:0] op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                          input logic c_i, output int lat, output logic [9:0] ctl_k,
                          output logic busy_k);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i; cin = c_i;
        @(posedge clk); #1;
        start = 1'b0;
        ctl_k  = ctl_now();
        busy_k = o_busy;
        lat = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (o_done) begin
                lat = i;
                break;
            end
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] res;
        logic [3:0] nzcv;
        logic       ill;
    } vec_t;

    vec_t vt[15];

    task automatic check_outputs(input string tag, input logic [7:0] res, input logic [3:0] nzcv,
                                 input logic ill, input int lat, input logic [9:0] ctl_k,
                                 input logic busy_k);
        chk({tag, " result"}, 64'(o_result), 64'(res));
        chk({tag, " nzcv"}, 64'({o_n, o_z, o_c, o_v}), 64'(nzcv));
        chk({tag, " illegal"}, 64'(o_illegal), 64'(ill));
        chk({tag, " latency"}, 64'(lat), ill ? 64'd1 : 64'd2);
        chk({tag, " busy"}, 64'(busy_k), 64'd1);
        if (ill) chk({tag, " ctl zero"}, 64'(ctl_k), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         lat, dones;
        logic [9:0] ctl_k;
        logic       busy_k, ill;
        logic [3:0] rop;
        logic [7:0] ra, rb;
        logic       rc;

        vt[0]  = '{OP_ADC, 8'h50, 8'h50, 1'b0, 8'hA0, 4'b1001, 1'b0};
        vt[1]  = '{OP_SBC, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b1000, 1'b0};
        vt[2]  = '{OP_CMP, 8'h40, 8'h40, 1'b0, 8'hFF, 4'b0110, 1'b0};
        vt[3]  = '{OP_ASL, 8'h81, 8'h00, 1'b0, 8'h02, 4'b0010, 1'b0};
        vt[4]  = '{OP_ROR, 8'h01, 8'h00, 1'b1, 8'h80, 4'b1010, 1'b0};
        vt[5]  = '{OP_LSR, 8'h01, 8'h00, 1'b0, 8'h00, 4'b0110, 1'b0};
        vt[6]  = '{OP_ADC, 8'h50, 8'h50, 1'b0, 8'hA0, 4'b1001, 1'b0};
        vt[7]  = '{OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 4'b0101, 1'b0};
        vt[8]  = '{OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 4'b1001, 1'b0};
        vt[9]  = '{OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0001, 1'b0};
        vt[10] = '{OP_EOR, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b0101, 1'b0};
        vt[11] = '{OP_ROL, 8'h80, 8'h00, 1'b1, 8'h01, 4'b0011, 1'b0};
        vt[12] = '{4'd13,  8'h55, 8'hAA, 1'b1, 8'h01, 4'b0011, 1'b1};
        vt[13] = '{OP_SBC, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011, 1'b0};
        vt[14] = '{OP_ORA, 8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b1011, 1'b0};

        // Reset state.
        #1;
        chk("reset status", 64'({o_busy, o_done, o_illegal}), 64'd0);
        chk("reset result", 64'({o_result, o_n, o_z, o_c, o_v}), 64'd0);
        chk("reset buses", 64'({o_sb, o_db, ctl_now()}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed table, issued back to back.
        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].c, lat, ctl_k, busy_k);
            model_apply(vt[i].op, vt[i].a, vt[i].b, vt[i].c, ill);
            check_outputs($sformatf("vec%0d", i), vt[i].res, vt[i].nzcv, vt[i].ill,
                          lat, ctl_k, busy_k);
        end

        // Done is a single-cycle pulse and controls are idle afterwards.
        @(posedge clk); #1;
        chk("done width", 64'(o_done), 64'd0);
        chk("idle ctl", 64'({o_sb, o_db, ctl_now()}), 64'd0);

        // Start held high across the whole operation: one op only.
        @(negedge clk);
        start = 1'b1; op = OP_ADC; a = 8'h01; b = 8'h01; cin = 1'b0;
        @(posedge clk); #1;
        chk("held exec ctl", 64'(ctl_now()), 64'b1100010000);
        dones = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 2) start = 1'b0;
            if (o_done) dones++;
        end
        model_apply(OP_ADC, 8'h01, 8'h01, 1'b0, ill);
        chk("held done count", 64'(dones), 64'd1);
        chk("held result", 64'(o_result), 64'(m_res));

        // Reset asserted during the execute cycle.
        @(negedge clk);
        start = 1'b1; op = OP_ADC; a = 8'h50; b = 8'h50; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("abort in exec", 64'(o_busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort status", 64'({o_busy, o_done, o_illegal}), 64'd0);
        chk("abort result", 64'({o_result, o_n, o_z, o_c, o_v}), 64'd0);
        chk("abort buses", 64'({o_sb, o_db, ctl_now()}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_res = 8'h00; m_n = 1'b0; m_z = 1'b0; m_c = 1'b0; m_v = 1'b0;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (o_done) dones++;
        end
        chk("abort no done", 64'(dones), 64'd0);

        run_op(OP_ORA, 8'hF0, 8'h0F, 1'b0, lat, ctl_k, busy_k);
        model_apply(OP_ORA, 8'hF0, 8'h0F, 1'b0, ill);
        check_outputs("post reset ora", 8'hFF, 4'b1000, 1'b0, lat, ctl_k, busy_k);

        // Random ops against the instruction-level model.
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rc  = 1'($urandom);
            run_op(rop, ra, rb, rc, lat, ctl_k, busy_k);
            model_apply(rop, ra, rb, rc, ill);
            check_outputs($sformatf("rnd%0d op%0d a%0h b%0h c%0d", i, rop, ra, rb, rc),
                          m_res, {m_n, m_z, m_c, m_v}, ill, lat, ctl_k, busy_k);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
